// File: rtl/hci_tcdm_responder.sv
// Target-side HCI/TCDM responder: word memory with byte-enable writes and fixed-latency reads.
// Optional pseudo-random grant stalls when HCI_RESPONDER_RANDOM_STALL_EN is defined.
module hci_tcdm_responder #(
    parameter int unsigned DW           = 32,
    parameter int unsigned AW           = 32,
    parameter int unsigned MEM_WORDS    = 1024,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned STALL_THRESH = 64,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    output logic              gnt,
    input  logic [AW-1:0]     add,
    input  logic              wen,
    input  logic [DW-1:0]     data,
    input  logic [DW/8-1:0]   be,
    output logic [DW-1:0]     r_data,
    output logic              r_valid,
    output logic [31:0]       n_reads,
    output logic [31:0]       n_writes,
    output logic [31:0]       n_stall_cycles
);

    localparam int unsigned BW   = DW / 8;
    localparam int unsigned OFFW = (BW > 1) ? $clog2(BW) : 0;
    localparam int unsigned IW   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
        $fatal(1, "hci_tcdm_responder: READ_LATENCY must be in 1..4");
    end
    if ((MEM_WORDS == 0) || ((MEM_WORDS & (MEM_WORDS - 1)) != 0)) begin : g_bad_words
        $fatal(1, "hci_tcdm_responder: MEM_WORDS must be a power of two");
    end
    if (LFSR_SEED == 16'h0000) begin : g_bad_seed
        $fatal(1, "hci_tcdm_responder: LFSR_SEED must be non-zero");
    end
    if ((DW % 8) != 0 || DW == 0) begin : g_bad_dw
        $fatal(1, "hci_tcdm_responder: DW must be a non-zero multiple of 8");
    end

    logic          stall;
    logic          rd_hs;
    logic          wr_hs;
    logic [IW-1:0] word_idx;
    logic [DW-1:0] rd_word;

    logic [DW-1:0] mem_q [MEM_WORDS];

    logic [READ_LATENCY-1:0] vld_q, vld_d;
    logic [DW-1:0]           pdata_q [READ_LATENCY];
    logic [DW-1:0]           pdata_d [READ_LATENCY];

    logic [31:0] n_reads_q, n_reads_d;
    logic [31:0] n_writes_q, n_writes_d;
    logic [31:0] n_stall_q, n_stall_d;

`ifdef HCI_RESPONDER_RANDOM_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        // Fibonacci taps 16,14,13,11 map to bits 15,13,12,10.
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        stall  = (32'(lfsr_q[7:0]) < STALL_THRESH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    logic unused_stall_cfg;
    assign unused_stall_cfg = ^{STALL_THRESH, LFSR_SEED};
    assign stall = 1'b0;
`endif

    // Byte-offset and upper address bits are intentionally ignored (wrap-around).
    logic unused_add;
    assign unused_add = ^add;

    always_comb begin
        gnt      = req & ~stall & rst_n;
        rd_hs    = req & gnt & wen;
        wr_hs    = req & gnt & ~wen;
        word_idx = add[OFFW +: IW];
        rd_word  = mem_q[word_idx];
    end

    always_ff @(posedge clk) begin
        if (wr_hs) begin
            for (int i = 0; i < BW; i++) begin
                if (be[i]) begin
                    mem_q[word_idx][8*i +: 8] <= data[8*i +: 8];
                end
            end
        end
    end

    // Data stages only move when carrying a valid beat, so the last stage holds
    // the most recently returned word while r_valid is low.
    always_comb begin
        vld_d[0]   = rd_hs;
        pdata_d[0] = rd_hs ? rd_word : pdata_q[0];
        for (int k = 1; k < READ_LATENCY; k++) begin
            vld_d[k]   = vld_q[k-1];
            pdata_d[k] = vld_q[k-1] ? pdata_q[k-1] : pdata_q[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                pdata_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int k = 0; k < READ_LATENCY; k++) begin
                pdata_q[k] <= pdata_d[k];
            end
        end
    end

    always_comb begin
        n_reads_d  = n_reads_q;
        n_writes_d = n_writes_q;
        n_stall_d  = n_stall_q;
        if (rd_hs && (n_reads_q != 32'hFFFF_FFFF)) begin
            n_reads_d = n_reads_q + 32'd1;
        end
        if (wr_hs && (n_writes_q != 32'hFFFF_FFFF)) begin
            n_writes_d = n_writes_q + 32'd1;
        end
        if (req && stall && (n_stall_q != 32'hFFFF_FFFF)) begin
            n_stall_d = n_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_reads_q  <= '0;
            n_writes_q <= '0;
            n_stall_q  <= '0;
        end else begin
            n_reads_q  <= n_reads_d;
            n_writes_q <= n_writes_d;
            n_stall_q  <= n_stall_d;
        end
    end

    assign r_valid        = vld_q[READ_LATENCY-1];
    assign r_data         = pdata_q[READ_LATENCY-1];
    assign n_reads        = n_reads_q;
    assign n_writes       = n_writes_q;
    assign n_stall_cycles = n_stall_q;

endmodule

// File: tb/tb_hci_tcdm_responder.sv
// Bench for hci_tcdm_responder: latency-1 and latency-3 instances share stimulus and are
// compared each cycle against a queue-based memory/response model.
module tb_hci_tcdm_responder;

    localparam int unsigned MW = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        wen;
    logic [31:0] add;
    logic [31:0] data;
    logic [3:0]  be;

    logic        gnt1, rv1, gnt3, rv3;
    logic [31:0] rd1, nr1, nw1, ns1, rd3, nr3, nw3, ns3;

    always #5 clk = ~clk;

    hci_tcdm_responder #(
        .DW(32), .AW(32), .MEM_WORDS(MW), .READ_LATENCY(1), .STALL_THRESH(128),
        .LFSR_SEED(16'hACE1)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt1), .add(add), .wen(wen),
        .data(data), .be(be), .r_data(rd1), .r_valid(rv1), .n_reads(nr1),
        .n_writes(nw1), .n_stall_cycles(ns1)
    );

    hci_tcdm_responder #(
        .DW(32), .AW(32), .MEM_WORDS(MW), .READ_LATENCY(3), .STALL_THRESH(128),
        .LFSR_SEED(16'hACE1)
    ) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt3), .add(add), .wen(wen),
        .data(data), .be(be), .r_data(rd3), .r_valid(rv3), .n_reads(nr3),
        .n_writes(nw3), .n_stall_cycles(ns3)
    );

    typedef struct {
        int          due;
        logic [31:0] d;
    } rsp_t;

    rsp_t        q1[$];
    rsp_t        q3[$];
    logic [31:0] mdl_mem [MW];
    logic [31:0] last1, last3;
    int unsigned m_nr, m_nw, m_ns;
    int          cyc;
    int          checks, errors;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % MW);
    endfunction

    task automatic model_clear();
        q1.delete();
        q3.delete();
        last1 = '0;
        last3 = '0;
        m_nr  = 0;
        m_nw  = 0;
        m_ns  = 0;
    endtask

    // One cycle: check outputs mid-cycle, then apply this cycle's handshake to the model.
    task automatic step();
        logic g;
        logic ev;
        int   w;
        @(negedge clk);
        ev = 1'b0;
        if (q1.size() > 0 && q1[0].due == cyc) begin
            ev    = 1'b1;
            last1 = q1[0].d;
            void'(q1.pop_front());
        end
        check_eq("r_valid_l1", 64'(rv1), 64'(ev));
        check_eq("r_data_l1", 64'(rd1), 64'(last1));
        ev = 1'b0;
        if (q3.size() > 0 && q3[0].due == cyc) begin
            ev    = 1'b1;
            last3 = q3[0].d;
            void'(q3.pop_front());
        end
        check_eq("r_valid_l3", 64'(rv3), 64'(ev));
        check_eq("r_data_l3", 64'(rd3), 64'(last3));
        check_eq("n_reads_l1", 64'(nr1), 64'(m_nr));
        check_eq("n_writes_l1", 64'(nw1), 64'(m_nw));
        check_eq("n_stall_l1", 64'(ns1), 64'(m_ns));
        check_eq("n_reads_l3", 64'(nr3), 64'(m_nr));
        check_eq("n_writes_l3", 64'(nw3), 64'(m_nw));
        check_eq("n_stall_l3", 64'(ns3), 64'(m_ns));
`ifdef HCI_RESPONDER_RANDOM_STALL_EN
        check_eq("gnt_without_req", 64'(gnt1 & ~req), 64'd0);
        check_eq("gnt_l1_vs_l3", 64'(gnt3), 64'(gnt1));
`else
        check_eq("gnt_l1", 64'(gnt1), 64'(req));
        check_eq("gnt_l3", 64'(gnt3), 64'(req));
`endif
        g = gnt1;
        @(posedge clk);
        w = widx(add);
        if (req && g) begin
            if (wen) begin
                q1.push_back('{due: cyc + 1, d: mdl_mem[w]});
                q3.push_back('{due: cyc + 3, d: mdl_mem[w]});
                m_nr++;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) mdl_mem[w][8*i +: 8] = data[8*i +: 8];
                end
                m_nw++;
            end
        end
        if (req && !g) m_ns++;
        cyc++;
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        req  = 1'b1;
        wen  = 1'b0;
        add  = a;
        data = d;
        be   = b;
        step();
    endtask

    task automatic rd(input logic [31:0] a);
        req  = 1'b1;
        wen  = 1'b1;
        add  = a;
        data = $urandom;
        be   = 4'($urandom);
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            req  = 1'b0;
            wen  = 1'($urandom);
            add  = $urandom;
            data = $urandom;
            be   = 4'($urandom);
            step();
        end
    endtask

    // Full-word writes to words 0..15 with random upper/offset address bits.
    task automatic preload();
        logic [31:0] a;
        for (int i = 0; i < 16; i++) begin
            a = ($urandom & 32'hFFFF_F000) | (32'(i) << 2) | ($urandom & 32'h3);
            wr(a, $urandom, 4'hF);
        end
    endtask

    initial begin
        logic [31:0] a;
        int unsigned nr0, ns0;
        checks = 0;
        errors = 0;
        cyc    = 0;
        model_clear();

        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            req  = 1'($urandom);
            wen  = 1'($urandom);
            add  = $urandom;
            data = $urandom;
            be   = 4'($urandom);
            @(negedge clk);
            check_eq("rst_gnt", 64'({gnt1, gnt3}), 64'd0);
            check_eq("rst_r_valid", 64'({rv1, rv3}), 64'd0);
            check_eq("rst_r_data", 64'(rd1 | rd3), 64'd0);
            check_eq("rst_counters", 64'(nr1 | nw1 | ns1 | nr3 | nw3 | ns3), 64'd0);
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        idle(3);

        wr(32'h10, 32'hDEAD_BEEF, 4'hF);
        rd(32'h10);
        idle(4);
        check_eq("wr_rd_data", 64'(rd1), 64'hDEAD_BEEF);
        check_eq("wr_rd_counts", 64'({nw1, nr1}), {32'd1, 32'd1});

        wr(32'h20, 32'h1122_3344, 4'hF);
        wr(32'h20, 32'hAABB_CCDD, 4'b0101);
        rd(32'h20);
        idle(4);
        check_eq("be_merge", 64'(rd1), 64'h11BB_33DD);

        for (int i = 0; i < 8; i++) wr(32'(i) << 2, 32'(i), 4'hF);
        for (int i = 0; i < 8; i++) rd(32'(i) << 2);
        idle(5);
        check_eq("stream_last_l3", 64'(rd3), 64'd7);

        wr(32'h0000_1004, 32'h5A5A_5A5A, 4'hF);
        rd(32'h0000_0004);
        idle(4);
        check_eq("wrap_data", 64'(rd1), 64'h5A5A_5A5A);

        preload();
        for (int n = 0; n < 400; n++) begin
            a    = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2)
                   | ($urandom & 32'h3);
            req  = ($urandom_range(0, 9) < 7);
            wen  = 1'($urandom);
            add  = a;
            data = $urandom;
            be   = 4'($urandom);
            step();
        end
        idle(4);

        // Asynchronous reset with responses in flight.
        wr(32'h4, 32'hCAFE_F00D, 4'hF);
        rd(32'h4);
        rd(32'h8);
        req = 1'b0;
        #2;
        check_eq("pre_rst_r_valid_l1", 64'(rv1), 64'd1);
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_r_valid", 64'({rv1, rv3}), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_clear();
        idle(6);

`ifdef HCI_RESPONDER_RANDOM_STALL_EN
        preload();
        nr0 = nr1;
        ns0 = ns1;
        for (int n = 0; n < 1000; n++) rd(32'($urandom_range(0, 15)) << 2);
        req = 1'b0;
        check_eq("stall_sum", 64'((nr1 - nr0) + (ns1 - ns0)), 64'd1000);
        check_eq("stall_range", 64'((ns1 - ns0) >= 400 && (ns1 - ns0) <= 600), 64'd1);
        idle(5);
`else
        nr0 = 0;
        ns0 = 0;
        check_eq("no_stall_count", 64'(ns1 + ns3 + ns0 + nr0), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
